video_sync_gen: RTL and testbench
=================================

Name: video_sync_gen

Overview:
- Horizontal/vertical video timing generator for the Centipede video path.
- Consumes the pixel-rate carry (rco) from the 4-bit synchronous counter stage and produces the raster counters, sync, blank and CPU interrupt strobes.
- Feeds the playfield/motion-object address logic and the CPU IRQ input.

Parameters:
H_TOTAL, 384, pixel-enable ticks per line (hcount 0..H_TOTAL-1)
H_ACTIVE, 256, visible pixels per line (hcount 0..H_ACTIVE-1)
H_SYNC_START, 288, first hcount with hsync asserted
H_SYNC_END, 320, first hcount with hsync deasserted
V_TOTAL, 262, lines per frame
V_ACTIVE, 240, visible lines
V_SYNC_START, 244, first vcount with vsync asserted
V_SYNC_END, 247, first vcount with vsync deasserted
IRQ_PERIOD, 64, lines between IRQ requests (power of two)

Ports:
clk  in  1  master clock
clr  in  1  asynchronous active-low reset
pix_en  in  1  pixel enable, rco of the upstream 4-bit counter; one-cycle pulse
hcount  out  9  horizontal position
vcount  out  9  vertical position
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
hblank  out  1  high when hcount >= H_ACTIVE
vblank  out  1  high when vcount >= V_ACTIVE
line_start  out  1  one-clk pulse on the clk where hcount wraps to 0
frame_start  out  1  one-clk pulse on the clk where hcount and vcount both wrap to 0
irq  out  1  level interrupt request to CPU
irq_ack  in  1  CPU acknowledge; clears irq

Behaviour:
- Reset (clr low, async): hcount=0, vcount=0, hsync=1, vsync=1, hblank=0, vblank=0, line_start=0, frame_start=0, irq=0. All outputs are registered.
- Deassertion of clr is sampled on clk. The first pix_en after release advances hcount 0->1.
- Counters advance only on clk edges with pix_en=1. With pix_en=0 every output holds, except line_start and frame_start, which return to 0.
- hcount: on pix_en, if hcount==H_TOTAL-1 then hcount=0 and vcount advances; otherwise hcount+1.
- vcount: advances only on the hcount wrap. At V_TOTAL-1 it wraps to 0.
- line_start=1 for exactly the clk on which hcount becomes 0. frame_start=1 only when vcount also becomes 0. Neither asserts out of reset.
- hsync=0 for hcount in [H_SYNC_START, H_SYNC_END); vsync=0 for vcount in [V_SYNC_START, V_SYNC_END).
- Sync and blank are decoded from the next counter value and registered, so they are aligned with hcount/vcount on the same clk (zero relative latency).
- IRQ state machine, states IDLE and PEND:
  - IDLE -> PEND when a line starts with vcount % IRQ_PERIOD == IRQ_PERIOD-16 (lines 48, 112, 176, 240 at defaults). irq=1 from that clk.
  - PEND -> IDLE on irq_ack=1. irq=0 on the following clk.
  - Trigger line reached while already in PEND: stay in PEND. No queued second request.
  - irq_ack and trigger on the same clk: trigger wins, irq stays 1.
  - irq_ack in IDLE: ignored.
- Width rules:
  - Counters are 9 bits unsigned. Compares are unsigned.
  - Parameters must satisfy H_ACTIVE <= H_SYNC_START < H_SYNC_END <= H_TOTAL <= 512, and likewise for V.
  - Elaboration fails (static check) otherwise.
- Reset mid-frame: immediate return to the reset state. A pending irq is dropped.

Test Plan:
- Reset then pix_en held 1 for 384 clks -> hcount runs 0..383 then 0; line_start pulses once at that wrap; vcount=1; hblank rises at hcount=256; hsync low for hcount 288..319.
- pix_en every 4th clk (upstream /4 rate) for one full line -> hcount advances only on enabled clks; line_start is exactly 1 clk wide; outputs stable between enables.
- Run 262 lines -> vblank high for vcount 240..261; vsync low for vcount 244..246; frame_start pulses once when vcount wraps 261->0.
- Frame with irq_ack never asserted -> irq rises at start of line 48 and stays 1 through lines 112, 176, 240; then irq_ack pulse -> irq=0 next clk.
- irq_ack held 1 on the start clk of line 112 while PEND -> irq remains 1; ack one clk later -> irq=0.
- clr pulsed low mid-line (hcount=200, vcount=130, irq=1) -> all outputs at reset values asynchronously; first pix_en after release gives hcount=1.

Source files
------------

// File: rtl/video_sync_gen.sv
// ----------------------------------------------------------------------------
// video_sync_gen
//
// Horizontal/vertical raster timing generator for the Centipede video path.
// It advances on the pixel-rate carry (pix_en) from the upstream 4-bit counter
// and produces the raster counters, active-low syncs, blanks, line/frame start
// strobes and a level CPU interrupt request.
//
// Ports:
//   clk          in   master clock
//   clr          in   asynchronous active-low reset
//   pix_en       in   pixel enable (one-cycle pulse from upstream rco)
//   irq_ack      in   CPU acknowledge; clears a pending irq
//   hcount[8:0]  out  horizontal position, 0..H_TOTAL-1
//   vcount[8:0]  out  vertical position, 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   hblank       out  high when hcount >= H_ACTIVE
//   vblank       out  high when vcount >= V_ACTIVE
//   line_start   out  one-clk pulse on the clk where hcount wraps to 0
//   frame_start  out  one-clk pulse when hcount and vcount both wrap to 0
//   irq          out  level interrupt request to the CPU
// ----------------------------------------------------------------------------
module video_sync_gen #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 288,
    parameter int H_SYNC_END   = 320,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_END   = 247,
    parameter int IRQ_PERIOD   = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pix_en,
    input  logic       irq_ack,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       line_start,
    output logic       frame_start,
    output logic       irq
);

    // Parameter sanity: refuse to elaborate an impossible raster.
    if (!(H_ACTIVE <= H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h
        $error("video_sync_gen: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE <= V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v
        $error("video_sync_gen: illegal vertical timing parameters");
    end
    if (!(IRQ_PERIOD >= 16 && IRQ_PERIOD <= 512 &&
          (IRQ_PERIOD & (IRQ_PERIOD - 1)) == 0)) begin : g_bad_irq
        $error("video_sync_gen: IRQ_PERIOD must be a power of two in 16..512");
    end

    // Sync/blank bounds may equal 512, so range compares use 10 bits.
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS     = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE     = 10'(H_SYNC_END);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS     = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE     = 10'(V_SYNC_END);
    localparam logic [8:0] IRQ_MASK = 9'(IRQ_PERIOD - 1);
    localparam logic [8:0] IRQ_LINE = 9'(IRQ_PERIOD - 16);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } irq_state_e;

    logic [8:0] hcount_q, hcount_d;
    logic [8:0] vcount_q, vcount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    irq_state_e state_q, state_d;
    logic       irq_trigger;

    // Raster counters and strobes. Sync/blank are decoded from the next
    // counter value so the registered versions line up with hcount/vcount.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = 9'd0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 9'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 9'd1;
                end
            end else begin
                hcount_d = hcount_q + 9'd1;
            end
        end
        hsync_d  = !(({1'b0, hcount_d} >= H_SS) && ({1'b0, hcount_d} < H_SE));
        vsync_d  = !(({1'b0, vcount_d} >= V_SS) && ({1'b0, vcount_d} < V_SE));
        hblank_d = ({1'b0, hcount_d} >= H_ACT);
        vblank_d = ({1'b0, vcount_d} >= V_ACT);
    end

    // IRQ period is a power of two, so the modulo reduces to a mask.
    assign irq_trigger = line_start_d && ((vcount_d & IRQ_MASK) == IRQ_LINE);

    // A trigger always wins over a simultaneous acknowledge; a trigger while
    // already pending is absorbed (no second request is queued).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_trigger) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!irq_trigger && irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hcount_q      <= 9'd0;
            vcount_q      <= 9'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            state_q       <= ST_IDLE;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign irq         = (state_q == ST_PEND);

endmodule

// File: tb/tb_video_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_video_sync_gen
//
// Bench for video_sync_gen. A shortened line (48 ticks) keeps a full frame of
// 262 lines affordable; vertical and IRQ timing use the default values.
// ----------------------------------------------------------------------------
module tb_video_sync_gen;

    localparam int HT   = 48;
    localparam int HA   = 32;
    localparam int HSS  = 36;
    localparam int HSE  = 40;
    localparam int VT   = 262;
    localparam int VA   = 240;
    localparam int VSS  = 244;
    localparam int VSE  = 247;
    localparam int IRQP = 64;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       pix_en = 1'b0;
    logic       irq_ack = 1'b0;
    logic [8:0] hcount, vcount;
    logic       hsync, vsync, hblank, vblank, line_start, frame_start, irq;

    video_sync_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .IRQ_PERIOD(IRQP)
    ) dut (
        .clk(clk), .clr(clr), .pix_en(pix_en), .irq_ack(irq_ack),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .line_start(line_start),
        .frame_start(frame_start), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hs, vs, hb, vb, ls, fs, irq;
    } obs_t;

    typedef struct {
        int   ncyc;
        int   div;
        logic ack;
        int   exp_h;
        int   exp_v;
        logic exp_irq;
    } vec_t;

    localparam obs_t RESET_OBS = '{h: 9'd0, v: 9'd0, hs: 1'b1, vs: 1'b1,
                                   hb: 1'b0, vb: 1'b0, ls: 1'b0, fs: 1'b0,
                                   irq: 1'b0};

    obs_t exp_q[$];
    vec_t vecs[9];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fs_seen = 0;
    int   ls_seen = 0;

    // Reference raster model
    int   m_h, m_v;
    logic m_irq, m_ls, m_fs;

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b irq=%b",
                         o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.ls, o.fs, o.irq);
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.h = hcount; o.v = vcount; o.hs = hsync; o.vs = vsync;
        o.hb = hblank; o.vb = vblank; o.ls = line_start; o.fs = frame_start;
        o.irq = irq;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.h   = 9'(m_h);
        o.v   = 9'(m_v);
        o.hs  = !(m_h >= HSS && m_h < HSE);
        o.vs  = !(m_v >= VSS && m_v < VSE);
        o.hb  = (m_h >= HA);
        o.vb  = (m_v >= VA);
        o.ls  = m_ls;
        o.fs  = m_fs;
        o.irq = m_irq;
        return o;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_irq = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step(input logic pen, input logic ack);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (pen) begin
            if (m_h == HT - 1) begin
                m_h  = 0;
                m_ls = 1'b1;
                m_v  = (m_v == VT - 1) ? 0 : m_v + 1;
                m_fs = (m_v == 0);
            end else begin
                m_h = m_h + 1;
            end
        end
        if (m_ls && (m_v % IRQP) == IRQP - 16) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one clock of stimulus, queue the expected result, and compare it
    // against the DUT on the following falling edge.
    task automatic cycle(input logic pen, input logic ack);
        obs_t e;
        pix_en  = pen;
        irq_ack = ack;
        model_step(pen, ack);
        exp_q.push_back(model_obs());
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            check_obs($sformatf("cycle@%0t", $time), dut_obs(), e);
        end
        if (frame_start === 1'b1) fs_seen++;
        if (line_start === 1'b1) ls_seen++;
    endtask

    task automatic run(input int n, input logic pen, input logic ack);
        for (int k = 0; k < n; k++) cycle(pen, ack);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Checkpoints after each segment, applied cumulatively from reset.
        vecs[0] = '{31,   1, 1'b0, 31, 0,   1'b0};  // just before hblank
        vecs[1] = '{1,    1, 1'b0, 32, 0,   1'b0};  // hblank rises
        vecs[2] = '{16,   1, 1'b0, 0,  1,   1'b0};  // first line wrap
        vecs[3] = '{192,  4, 1'b0, 0,  2,   1'b0};  // pix_en every 4th clk
        vecs[4] = '{2208, 1, 1'b0, 0,  48,  1'b1};  // line 48 raises irq
        vecs[5] = '{3072, 1, 1'b0, 0,  112, 1'b1};  // still pending
        vecs[6] = '{3072, 1, 1'b0, 0,  176, 1'b1};
        vecs[7] = '{3072, 1, 1'b0, 0,  240, 1'b1};  // vblank region
        vecs[8] = '{1056, 1, 1'b0, 0,  0,   1'b1};  // frame wrap 261 -> 0

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_obs("reset_state", dut_obs(), RESET_OBS);
        clr = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < vecs[i].ncyc; c++)
                cycle((c % vecs[i].div) == vecs[i].div - 1, vecs[i].ack);
            check_int($sformatf("vec%0d_hcount", i), int'(hcount), vecs[i].exp_h);
            check_int($sformatf("vec%0d_vcount", i), int'(vcount), vecs[i].exp_v);
            check_int($sformatf("vec%0d_irq", i), int'(irq), int'(vecs[i].exp_irq));
            if (i == 2) check_int("line_start_count_first_line", ls_seen, 1);
        end
        check_int("frame_start_count", fs_seen, 1);

        // Acknowledge with no trigger: irq drops on the next clk.
        cycle(1'b0, 1'b1);
        check_int("ack_clears_irq", int'(irq), 0);
        cycle(1'b0, 1'b0);

        // Reach the last tick of line 111 (line 48 re-armed the request).
        run(111 * HT + HT - 1, 1'b1, 1'b0);
        check_int("pre112_hcount", int'(hcount), HT - 1);
        check_int("pre112_irq", int'(irq), 1);
        // Ack coincides with the line-112 trigger: trigger wins.
        cycle(1'b1, 1'b1);
        check_int("ack_vs_trigger_v", int'(vcount), 112);
        check_int("ack_vs_trigger_irq", int'(irq), 1);
        cycle(1'b0, 1'b1);
        check_int("late_ack_clears", int'(irq), 0);
        cycle(1'b0, 1'b1);
        check_int("ack_in_idle", int'(irq), 0);

        // Mid-line, mid-frame with irq pending, then asynchronous reset.
        run(68 * HT + 20, 1'b1, 1'b0);
        check_int("prereset_h", int'(hcount), 20);
        check_int("prereset_v", int'(vcount), 180);
        check_int("prereset_irq", int'(irq), 1);
        pix_en = 1'b1;
        #2;
        clr = 1'b0;
        #1;
        check_obs("async_reset", dut_obs(), RESET_OBS);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_obs("reset_held", dut_obs(), RESET_OBS);
        clr = 1'b1;
        cycle(1'b1, 1'b0);
        check_int("first_pix_after_reset", int'(hcount), 1);
        run(HT + 5, 1'b1, 1'b0);
        check_int("post_reset_v", int'(vcount), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
